// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Arbitrates the single write port of the 32x32 integer register file
// between two producers. Each producer has its own small FIFO.
//   clk, rst               : single clock, synchronous active-high reset
//   a_valid/a_ready/a_reg/a_data : requester A (ALU results)
//   b_valid/b_ready/b_reg/b_data : requester B (load/memory results)
//   EnableWrite/write_reg/write_data : registered register-file write port
//   pending                : per-register mask of accepted, uncommitted writes
module regfile_wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [4:0]        a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [4:0]        b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              EnableWrite,
  output logic [4:0]        write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [31:0]       pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [4:0]        a_reg_mem_q  [DEPTH];
  logic [4:0]        a_reg_mem_d  [DEPTH];
  logic [DATA_W-1:0] a_data_mem_q [DEPTH];
  logic [DATA_W-1:0] a_data_mem_d [DEPTH];
  logic [PTR_W-1:0]  a_wr_ptr_q, a_wr_ptr_d, a_rd_ptr_q, a_rd_ptr_d;
  logic [CNT_W-1:0]  a_count_q, a_count_d;

  logic [4:0]        b_reg_mem_q  [DEPTH];
  logic [4:0]        b_reg_mem_d  [DEPTH];
  logic [DATA_W-1:0] b_data_mem_q [DEPTH];
  logic [DATA_W-1:0] b_data_mem_d [DEPTH];
  logic [PTR_W-1:0]  b_wr_ptr_q, b_wr_ptr_d, b_rd_ptr_q, b_rd_ptr_d;
  logic [CNT_W-1:0]  b_count_q, b_count_d;

  // rr_ptr: 0 = A has priority on the next contended grant, 1 = B
  logic              rr_ptr_q, rr_ptr_d;
  logic              enable_write_q, enable_write_d;
  logic [4:0]        write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic a_push, b_push, a_ne, b_ne, grant_a, grant_b;

  // Ready depends only on occupancy, so a full FIFO never takes a new
  // entry in the cycle it pops.
  assign a_ready = (a_count_q < FULL) && !rst;
  assign b_ready = (b_count_q < FULL) && !rst;
  assign a_push  = a_valid && a_ready;
  assign b_push  = b_valid && b_ready;
  assign a_ne    = (a_count_q != '0);
  assign b_ne    = (b_count_q != '0);
  assign grant_a = a_ne && (!b_ne || !rr_ptr_q);
  assign grant_b = b_ne && (!a_ne ||  rr_ptr_q);

  always_comb begin
    a_reg_mem_d  = a_reg_mem_q;
    a_data_mem_d = a_data_mem_q;
    a_wr_ptr_d   = a_wr_ptr_q;
    a_rd_ptr_d   = a_rd_ptr_q;
    a_count_d    = a_count_q;
    if (a_push) begin
      a_reg_mem_d[a_wr_ptr_q]  = a_reg;
      a_data_mem_d[a_wr_ptr_q] = a_data;
      a_wr_ptr_d = a_wr_ptr_q + PTR_W'(1);
    end
    if (grant_a) a_rd_ptr_d = a_rd_ptr_q + PTR_W'(1);
    case ({a_push, grant_a})
      2'b10:   a_count_d = a_count_q + CNT_W'(1);
      2'b01:   a_count_d = a_count_q - CNT_W'(1);
      default: a_count_d = a_count_q;
    endcase
  end

  always_comb begin
    b_reg_mem_d  = b_reg_mem_q;
    b_data_mem_d = b_data_mem_q;
    b_wr_ptr_d   = b_wr_ptr_q;
    b_rd_ptr_d   = b_rd_ptr_q;
    b_count_d    = b_count_q;
    if (b_push) begin
      b_reg_mem_d[b_wr_ptr_q]  = b_reg;
      b_data_mem_d[b_wr_ptr_q] = b_data;
      b_wr_ptr_d = b_wr_ptr_q + PTR_W'(1);
    end
    if (grant_b) b_rd_ptr_d = b_rd_ptr_q + PTR_W'(1);
    case ({b_push, grant_b})
      2'b10:   b_count_d = b_count_q + CNT_W'(1);
      2'b01:   b_count_d = b_count_q - CNT_W'(1);
      default: b_count_d = b_count_q;
    endcase
  end

  // Output stage: a popped r0 write is consumed but never strobed.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    enable_write_d = 1'b0;
    write_reg_d    = write_reg_q;
    write_data_d   = write_data_q;
    if (a_ne && b_ne) rr_ptr_d = ~rr_ptr_q;
    if (grant_a) begin
      write_reg_d    = a_reg_mem_q[a_rd_ptr_q];
      write_data_d   = a_data_mem_q[a_rd_ptr_q];
      enable_write_d = (a_reg_mem_q[a_rd_ptr_q] != 5'd0);
    end else if (grant_b) begin
      write_reg_d    = b_reg_mem_q[b_rd_ptr_q];
      write_data_d   = b_data_mem_q[b_rd_ptr_q];
      enable_write_d = (b_reg_mem_q[b_rd_ptr_q] != 5'd0);
    end
  end

  // Occupied slots are the count entries starting at the read pointer.
  always_comb begin
    logic [31:0]      pend;
    logic [PTR_W-1:0] slot;
    pend = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = a_rd_ptr_q + PTR_W'(k);
      if (CNT_W'(k) < a_count_q) pend[a_reg_mem_q[slot]] = 1'b1;
      slot = b_rd_ptr_q + PTR_W'(k);
      if (CNT_W'(k) < b_count_q) pend[b_reg_mem_q[slot]] = 1'b1;
    end
    if (enable_write_q) pend[write_reg_q] = 1'b1;
    pend[0] = 1'b0;
    pending = pend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_wr_ptr_q     <= '0;
      a_rd_ptr_q     <= '0;
      a_count_q      <= '0;
      b_wr_ptr_q     <= '0;
      b_rd_ptr_q     <= '0;
      b_count_q      <= '0;
      rr_ptr_q       <= 1'b0;
      enable_write_q <= 1'b0;
      write_reg_q    <= '0;
      write_data_q   <= '0;
    end else begin
      a_wr_ptr_q     <= a_wr_ptr_d;
      a_rd_ptr_q     <= a_rd_ptr_d;
      a_count_q      <= a_count_d;
      b_wr_ptr_q     <= b_wr_ptr_d;
      b_rd_ptr_q     <= b_rd_ptr_d;
      b_count_q      <= b_count_d;
      rr_ptr_q       <= rr_ptr_d;
      enable_write_q <= enable_write_d;
      write_reg_q    <= write_reg_d;
      write_data_q   <= write_data_d;
    end
  end

  // Storage needs no reset: slots outside the count window are never read.
  always_ff @(posedge clk) begin
    a_reg_mem_q  <= a_reg_mem_d;
    a_data_mem_q <= a_data_mem_d;
    b_reg_mem_q  <= b_reg_mem_d;
    b_data_mem_q <= b_data_mem_d;
  end

  assign EnableWrite = enable_write_q;
  assign write_reg   = write_reg_q;
  assign write_data  = write_data_q;

endmodule
